// File: rtl/lane_ctrl_pkg.sv
// Shared types and helpers for the read-lane alignment controller.
// Holds the FSM encoding and the per-lane count slicer used on the flat occupancy bus.
package lane_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT2 = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Upper bounds that size the slicer; callers zero-extend their bus to MAX_FLAT_W.
  localparam int unsigned MAX_LANES  = 18;
  localparam int unsigned MAX_CNT_W  = 8;
  localparam int unsigned MAX_FLAT_W = MAX_LANES * MAX_CNT_W;

  function automatic logic [MAX_CNT_W-1:0] lane_cnt(
    input logic [MAX_FLAT_W-1:0] flat,
    input int unsigned           lane,
    input int unsigned           cnt_w
  );
    logic [MAX_FLAT_W-1:0] shifted;
    logic [MAX_CNT_W-1:0]  mask;
    shifted = flat >> (lane * cnt_w);
    mask    = MAX_CNT_W'((1 << cnt_w) - 1);
    return shifted[MAX_CNT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/lane_rd_valid_dly.sv
// Fixed-latency delay line for the pop indication; stage 0 captures the input,
// the last stage is the registered dfi_rddata_valid.
module lane_rd_valid_dly #(
  parameter int VALID_LATENCY = 1
) (
  input  logic SCLK,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [VALID_LATENCY-1:0] stage;

  // NOTE: every stage is a plain flop, so it is reset like any other state; only
  // reset clears it, so valids already in flight always drain out.
  always_ff @(posedge SCLK) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < VALID_LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[VALID_LATENCY-1];

endmodule

// File: rtl/lane_rd_align_ctrl.sv
// Pops all DQS lane read FIFOs in lockstep once every enabled lane is ready,
// with 2-beat bursts, flush draining and a sticky lane-skew timeout.
module lane_rd_align_ctrl
  import lane_ctrl_pkg::*;
#(
  parameter int IOG_DQS_LANES       = 2,
  parameter int CNT_W               = 3,
  parameter int MIN_ENTRIES_IN_FIFO = 1,
  parameter int VALID_LATENCY       = 1,
  parameter int TIMEOUT_CYCLES      = 15,
  parameter int TO_W                = 4
) (
  input  logic                           SCLK,
  input  logic                           reset,
  input  logic [IOG_DQS_LANES*CNT_W-1:0] entries_in_FIFO_cnt,
  input  logic [IOG_DQS_LANES-1:0]       lane_enable,
  input  logic                           burst2,
  input  logic                           flush,
  input  logic                           err_clr,
  output logic                           read_FIFO_en,
  output logic                           dfi_rddata_valid,
  output logic                           lane_skew_err,
  output logic [IOG_DQS_LANES-1:0]       err_lane_mask,
  output logic                           flush_busy
);

  localparam logic [CNT_W:0]  MIN_THR = (CNT_W+1)'(MIN_ENTRIES_IN_FIFO);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_HIT  = TO_W'(TIMEOUT_CYCLES - 1);

  state_e                   state, state_nxt;
  logic [MAX_FLAT_W-1:0]    cnt_flat;
  logic [CNT_W:0]           thr;
  logic [IOG_DQS_LANES-1:0] lane_ready, lane_nz;
  logic                     all_ready, skew, to_hit, valid_in;
  logic [TO_W-1:0]          to_cnt;

  assign cnt_flat = MAX_FLAT_W'(entries_in_FIFO_cnt);
  assign thr      = burst2 ? (MIN_THR << 1) : MIN_THR;

  // NOTE: every variable written in always_comb gets a default first, so no path
  // leaves it holding its old value (which would infer a latch).
  always_comb begin
    lane_ready = '0;
    lane_nz    = '0;
    for (int i = 0; i < IOG_DQS_LANES; i++) begin
      lane_ready[i] = ~lane_enable[i] | ({1'b0, CNT_W'(lane_cnt(cnt_flat, i, CNT_W))} >= thr);
      lane_nz[i]    =  lane_enable[i] & (CNT_W'(lane_cnt(cnt_flat, i, CNT_W)) != '0);
    end
  end

  assign all_ready = (&lane_ready) & (|lane_enable);

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // sample their inputs from the same side of the clock edge.
  always_ff @(posedge SCLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (flush)                    state_nxt = ST_FLUSH;
        else if (all_ready && burst2) state_nxt = ST_BEAT2;
      end
      ST_BEAT2: state_nxt = ST_IDLE;
      ST_FLUSH: if (!flush) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    read_FIFO_en = 1'b0;
    flush_busy   = 1'b0;
    case (state)
      ST_IDLE:  read_FIFO_en = ~flush & all_ready;
      ST_BEAT2: read_FIFO_en = 1'b1;
      ST_FLUSH: begin
        read_FIFO_en = |lane_nz;
        flush_busy   = |lane_nz;
      end
      default: ;
    endcase
    if (reset) read_FIFO_en = 1'b0;
  end

  assign valid_in = read_FIFO_en & (state != ST_FLUSH);

  lane_rd_valid_dly #(
    .VALID_LATENCY(VALID_LATENCY)
  ) u_valid_dly (
    .SCLK  (SCLK),
    .reset (reset),
    .din   (valid_in),
    .dout  (dfi_rddata_valid)
  );

  assign skew   = (state == ST_IDLE) & ~flush & (|lane_nz) & ~all_ready;
  assign to_hit = skew & (to_cnt == TO_HIT);

  // err_clr also restarts the count so a persisting skew can time out again.
  always_ff @(posedge SCLK) begin
    if (reset) begin
      to_cnt        <= '0;
      lane_skew_err <= 1'b0;
      err_lane_mask <= '0;
    end else begin
      if (!skew || err_clr)  to_cnt <= '0;
      else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);

      if (to_hit) begin
        lane_skew_err <= 1'b1;
        if (!lane_skew_err || err_clr) err_lane_mask <= ~lane_ready;
      end else if (err_clr) begin
        lane_skew_err <= 1'b0;
        err_lane_mask <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lane_rd_align_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level behavioural model with FIFO occupancy kept as plain integers.
module tb_lane_rd_align_ctrl;

  localparam int LANES   = 2;
  localparam int CNT_W   = 3;
  localparam int MIN     = 1;
  localparam int TMO     = 15;
  localparam int TO_W    = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   SCLK = 1'b0;
  logic                   reset;
  logic [LANES*CNT_W-1:0] cnt_bus;
  logic [LANES-1:0]       lane_enable;
  logic                   burst2, flush, err_clr;
  logic                   rd_en_a, valid_a, err_a, busy_a;
  logic [LANES-1:0]       mask_a;
  logic                   rd_en_b, valid_b, err_b, busy_b;
  logic [LANES-1:0]       mask_b;

  always #5 SCLK = ~SCLK;

  lane_rd_align_ctrl #(
    .IOG_DQS_LANES(LANES), .CNT_W(CNT_W), .MIN_ENTRIES_IN_FIFO(MIN),
    .VALID_LATENCY(1), .TIMEOUT_CYCLES(TMO), .TO_W(TO_W)
  ) u_dut_l1 (
    .SCLK(SCLK), .reset(reset), .entries_in_FIFO_cnt(cnt_bus),
    .lane_enable(lane_enable), .burst2(burst2), .flush(flush), .err_clr(err_clr),
    .read_FIFO_en(rd_en_a), .dfi_rddata_valid(valid_a), .lane_skew_err(err_a),
    .err_lane_mask(mask_a), .flush_busy(busy_a)
  );

  lane_rd_align_ctrl #(
    .IOG_DQS_LANES(LANES), .CNT_W(CNT_W), .MIN_ENTRIES_IN_FIFO(MIN),
    .VALID_LATENCY(4), .TIMEOUT_CYCLES(TMO), .TO_W(TO_W)
  ) u_dut_l4 (
    .SCLK(SCLK), .reset(reset), .entries_in_FIFO_cnt(cnt_bus),
    .lane_enable(lane_enable), .burst2(burst2), .flush(flush), .err_clr(err_clr),
    .read_FIFO_en(rd_en_b), .dfi_rddata_valid(valid_b), .lane_skew_err(err_b),
    .err_lane_mask(mask_b), .flush_busy(busy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: FIFO occupancies, pending second beat, flushing flag,
  // skew age, sticky error and a history of valid-producing pops.
  int               fc[LANES];
  bit               m_beat2, m_flush, m_err;
  int               m_to;
  logic [LANES-1:0] m_mask;
  bit               vhist[8];
  int               pops_seen, valids_seen;

  task automatic model_clear();
    m_beat2 = 0; m_flush = 0; m_err = 0; m_to = 0; m_mask = '0;
    for (int k = 0; k < 8; k++) vhist[k] = 0;
    for (int i = 0; i < LANES; i++) fc[i] = 0;
  endtask

  task automatic tick();
    bit               pop, busy, skew, all_rdy, any_nz, hit;
    logic [LANES-1:0] rdy;
    int               thr;
    for (int i = 0; i < LANES; i++) cnt_bus[i*CNT_W +: CNT_W] = CNT_W'(fc[i]);
    #1;
    thr    = MIN * (burst2 ? 2 : 1);
    any_nz = 0;
    rdy    = '0;
    for (int i = 0; i < LANES; i++) begin
      rdy[i] = !lane_enable[i] || (fc[i] >= thr);
      if (lane_enable[i] && fc[i] != 0) any_nz = 1;
    end
    all_rdy = (rdy == '1) && (lane_enable != '0);
    busy    = m_flush && any_nz;
    if (m_beat2)      pop = 1;
    else if (m_flush) pop = any_nz;
    else              pop = !flush && all_rdy;
    if (reset) pop = 0;
    skew = !m_beat2 && !m_flush && !flush && any_nz && !all_rdy;

    check("rd_en",      32'(rd_en_a), 32'(pop));
    check("rd_en_l4",   32'(rd_en_b), 32'(pop));
    check("flush_busy", 32'(busy_a),  32'(busy));
    check("valid_l1",   32'(valid_a), 32'(vhist[0]));
    check("valid_l4",   32'(valid_b), 32'(vhist[3]));
    check("skew_err",   32'(err_a),   32'(m_err));
    check("err_mask",   32'(mask_a),  32'(m_mask));
    check("err_mask_l4",32'(mask_b),  32'(m_mask));
    if (rd_en_a) pops_seen++;
    if (valid_a) valids_seen++;

    @(posedge SCLK);
    if (reset) begin
      model_clear();
    end else begin
      hit = skew && (m_to == TMO - 1);
      for (int k = 7; k > 0; k--) vhist[k] = vhist[k-1];
      vhist[0] = pop && !m_flush;
      if (hit) begin
        if (!m_err || err_clr) m_mask = ~rdy;
        m_err = 1;
      end else if (err_clr) begin
        m_err  = 0;
        m_mask = '0;
      end
      m_to = (err_clr || !skew) ? 0 : ((m_to < TMO) ? m_to + 1 : TMO);
      if (m_beat2)               m_beat2 = 0;
      else if (m_flush)          m_flush = flush;
      else if (flush)            m_flush = 1;
      else if (all_rdy && burst2) m_beat2 = 1;
      if (pop) for (int i = 0; i < LANES; i++) if (fc[i] > 0) fc[i]--;
    end
    @(negedge SCLK);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic zero_counters();
    pops_seen = 0; valids_seen = 0;
  endtask

  initial begin
    reset = 1; lane_enable = 2'b11; burst2 = 0; flush = 0; err_clr = 0;
    cnt_bus = '0;
    model_clear();
    @(negedge SCLK);
    ticks(2);
    reset = 0;
    check("reset_rd_en", 32'(rd_en_a), 32'd0);
    check("reset_valid", 32'(valid_b), 32'd0);

    // Single-beat streaming: 3 entries per lane -> 3 pops, 3 valids one cycle later.
    fc[0] = 3; fc[1] = 3; zero_counters();
    ticks(6);
    check("stream_pops",   32'(pops_seen),   32'd3);
    check("stream_valids", 32'(valids_seen), 32'd3);

    // Burst2: lane0 short by one entry holds off, then exactly one 2-beat burst.
    burst2 = 1; fc[0] = 1; fc[1] = 2; zero_counters();
    ticks(3);
    check("burst_hold_pops", 32'(pops_seen), 32'd0);
    fc[0] = 2;
    ticks(4);
    check("burst_pops", 32'(pops_seen), 32'd2);

    // Lane mask: only lane0 participates; then no lanes -> never pops.
    burst2 = 0; lane_enable = 2'b01; fc[0] = 1; fc[1] = 0; zero_counters();
    ticks(3);
    check("mask_pops", 32'(pops_seen), 32'd1);
    lane_enable = 2'b00; fc[0] = 3; fc[1] = 3; zero_counters();
    ticks(5);
    check("none_enabled_pops", 32'(pops_seen), 32'd0);

    // Skew timeout: lane1 empty while lane0 waits.
    lane_enable = 2'b11; fc[0] = 1; fc[1] = 0;
    ticks(17);
    check("skew_set",  32'(err_a),  32'd1);
    check("skew_mask", 32'(mask_a), 32'b10);
    err_clr = 1; tick(); err_clr = 0;
    check("skew_clr",      32'(err_a),  32'd0);
    check("skew_clr_mask", 32'(mask_a), 32'd0);
    ticks(14);
    check("skew_not_yet", 32'(err_a), 32'd0);
    ticks(2);
    check("skew_reset_again", 32'(err_a), 32'd1);
    fc[1] = 1; ticks(2);
    err_clr = 1; tick(); err_clr = 0;
    ticks(3);

    // Flush: drains 3 beats without producing valid.
    fc[0] = 3; fc[1] = 1; flush = 1; zero_counters();
    ticks(5);
    check("flush_pops",   32'(pops_seen),   32'd3);
    check("flush_valids", 32'(valids_seen), 32'd0);
    check("flush_done",   32'(busy_a),      32'd0);
    flush = 0; tick();

    // Flush raised during the second beat: burst still completes with valid.
    burst2 = 1; fc[0] = 2; fc[1] = 2; zero_counters();
    tick();
    flush = 1;
    ticks(3);
    check("beat2_flush_valids", 32'(valids_seen), 32'd2);
    flush = 0; ticks(2);

    // Reset in BEAT2 with valids in flight through the 4-deep line.
    fc[0] = 4; fc[1] = 4;
    tick();
    reset = 1; tick(); reset = 0;
    check("rst_mid_valid_l4", 32'(valid_b), 32'd0);
    check("rst_mid_rd_en",    32'(rd_en_a), 32'd0);
    check("rst_mid_err",      32'(err_a),   32'd0);
    ticks(3);

    // Random traffic with per-segment lane arrival rates to provoke skew.
    begin
      int rate[LANES];
      for (int c = 0; c < 4000; c++) begin
        if (c % 64 == 0) for (int i = 0; i < LANES; i++) rate[i] = $urandom_range(0, 4);
        for (int i = 0; i < LANES; i++)
          if ($urandom_range(0, 7) < rate[i]) fc[i] = (fc[i] + 1 > CNT_MAX) ? CNT_MAX : fc[i] + 1;
        if ($urandom_range(0, 49) == 0) lane_enable = LANES'($urandom_range(0, 3));
        else if ($urandom_range(0, 29) == 0) lane_enable = 2'b11;
        if ($urandom_range(0, 19) == 0) burst2 = $urandom_range(0, 1) != 0;
        if ($urandom_range(0, 39) == 0) flush = ~flush;
        err_clr = ($urandom_range(0, 29) == 0);
        reset   = ($urandom_range(0, 599) == 0);
        tick();
      end
      reset = 0; err_clr = 0; flush = 0;
      ticks(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
